// File: rtl/dct_pkg.sv
// Shared constants and types for the 8x8 DCT transpose buffer.
package dct_pkg;

  localparam int DCT_N      = 8;
  localparam int DCT_COEF_W = 11;

  typedef enum logic {
    IDLE,
    READ
  } rd_state_t;

endpackage

// File: rtl/dct_transpose_bank.sv
// One 8x8 coefficient bank: a whole row is written at once and a whole column is read at once.
module tp_bank
  import dct_pkg::*;
#(
  parameter int W = DCT_COEF_W,
  parameter int N = DCT_N
) (
  input  logic               clk,
  input  logic               we,
  input  logic [2:0]         row,
  input  logic [N-1:0][W-1:0] wdata,
  input  logic [2:0]         col,
  output logic [N-1:0][W-1:0] rdata
);

  logic [W-1:0] mem [N][N];

  // Store a full row; contents need no reset because a block is always fully written before it is read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < N; c++) begin
        mem[row][c] <= wdata[c];
      end
    end
  end

  // Gather the selected column across all rows.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      rdata[r] = mem[r][col];
    end
  end

endmodule

// File: rtl/dct_transpose.sv
// Ping-pong transpose buffer: rows from the row-pass DCT in, columns to the column-pass DCT out.
module dct_transpose
  import dct_pkg::*;
#(
  parameter int W = DCT_COEF_W,
  parameter int N = DCT_N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic signed [W-1:0] d0,
  input  logic signed [W-1:0] d1,
  input  logic signed [W-1:0] d2,
  input  logic signed [W-1:0] d3,
  input  logic signed [W-1:0] d4,
  input  logic signed [W-1:0] d5,
  input  logic signed [W-1:0] d6,
  input  logic signed [W-1:0] d7,
  output logic                out_valid,
  output logic signed [W-1:0] q0,
  output logic signed [W-1:0] q1,
  output logic signed [W-1:0] q2,
  output logic signed [W-1:0] q3,
  output logic signed [W-1:0] q4,
  output logic signed [W-1:0] q5,
  output logic signed [W-1:0] q6,
  output logic signed [W-1:0] q7,
  output logic                out_first,
  output logic                out_last
);

  logic [N-1:0][W-1:0] wdata;
  logic [N-1:0][W-1:0] rdata0;
  logic [N-1:0][W-1:0] rdata1;
  logic [N-1:0][W-1:0] rdata_sel;
  logic [N-1:0][W-1:0] q_reg;
  logic [2:0]          wrow;
  logic [2:0]          rcol;
  logic                wsel;
  logic                launch;
  rd_state_t           state;

  assign wdata  = {d7, d6, d5, d4, d3, d2, d1, d0};
  assign launch = in_valid && (wrow == 3'd7);

  // The read bank is always the one not being written; after a launch wsel has already
  // moved on, so the just-filled bank is exactly ~wsel for the whole read.
  assign rdata_sel = wsel ? rdata0 : rdata1;

  assign q0 = q_reg[0];
  assign q1 = q_reg[1];
  assign q2 = q_reg[2];
  assign q3 = q_reg[3];
  assign q4 = q_reg[4];
  assign q5 = q_reg[5];
  assign q6 = q_reg[6];
  assign q7 = q_reg[7];

  tp_bank #(.W(W), .N(N)) u_bank0 (
    .clk   (clk),
    .we    (in_valid && !wsel),
    .row   (wrow),
    .wdata (wdata),
    .col   (rcol),
    .rdata (rdata0)
  );

  tp_bank #(.W(W), .N(N)) u_bank1 (
    .clk   (clk),
    .we    (in_valid && wsel),
    .row   (wrow),
    .wdata (wdata),
    .col   (rcol),
    .rdata (rdata1)
  );

  // Write side: advance the row pointer per accepted row and flip banks after the eighth row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrow <= 3'd0;
      wsel <= 1'b0;
    end else if (in_valid) begin
      wrow <= wrow + 3'd1;
      if (wrow == 3'd7) begin
        wsel <= ~wsel;
      end
    end
  end

  // Read FSM: stream eight columns per launch, chaining straight into the next block if one lands on the last column.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rcol      <= 3'd0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      q_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          out_first <= 1'b0;
          out_last  <= 1'b0;
          if (launch) begin
            state <= READ;
            rcol  <= 3'd0;
          end
        end
        READ: begin
          q_reg     <= rdata_sel;
          out_valid <= 1'b1;
          out_first <= (rcol == 3'd0);
          out_last  <= (rcol == 3'd7);
          rcol      <= rcol + 3'd1;
          if (rcol == 3'd7 && !launch) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct_transpose.sv
// Directed bench for dct_transpose: single, back-to-back, extreme, gapped and reset scenarios.
module tb_dct_transpose;

  localparam int W = 11;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic signed [W-1:0] d4 = '0, d5 = '0, d6 = '0, d7 = '0;
  logic                out_valid, out_first, out_last;
  logic signed [W-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic [8*W-1:0]      q_all;

  int errors = 0;
  int checks = 0;

  assign q_all = {q7, q6, q5, q4, q3, q2, q1, q0};

  dct_transpose #(.W(W), .N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .d0 (d0), .d1 (d1), .d2 (d2), .d3 (d3),
    .d4 (d4), .d5 (d5), .d6 (d6), .d7 (d7),
    .out_valid (out_valid),
    .q0 (q0), .q1 (q1), .q2 (q2), .q3 (q3),
    .q4 (q4), .q5 (q5), .q6 (q6), .q7 (q7),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Mode 0: 8r+c, mode 1: -(8r+c), mode 2: -1024 on even rows, +1023 on odd rows.
  function automatic logic [W-1:0] val(input int mode, input int r, input int c);
    int v;
    if (mode == 0)      v = 8 * r + c;
    else if (mode == 1) v = -(8 * r + c);
    else                v = (r % 2 == 0) ? -1024 : 1023;
    return v[W-1:0];
  endfunction

  function automatic logic [8*W-1:0] exp_col(input int mode, input int c);
    logic [8*W-1:0] e;
    e = '0;
    for (int r = 0; r < 8; r++) e[r*W +: W] = val(mode, r, c);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int mode, input int r);
    d0 = val(mode, r, 0); d1 = val(mode, r, 1); d2 = val(mode, r, 2); d3 = val(mode, r, 3);
    d4 = val(mode, r, 4); d5 = val(mode, r, 5); d6 = val(mode, r, 6); d7 = val(mode, r, 7);
    in_valid = 1'b1;
  endtask

  task automatic set_idle();
    in_valid = 1'b0;
    d0 = 11'h2A5; d1 = 11'h15A; d2 = 11'h2A5; d3 = 11'h15A;
    d4 = 11'h2A5; d5 = 11'h15A; d6 = 11'h2A5; d7 = 11'h15A;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: valid=%b first=%b last=%b, expected 0 0 0", out_valid, out_first, out_last);
    end
    checks++;
    if (q_all !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 0", q_all);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_block();
    for (int r = 0; r < 8; r++) begin
      set_row(0, r);
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL single_early row %0d: valid=%b expected 0", r, out_valid);
      end
    end
    set_idle();
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_first !== (c == 0) || out_last !== (c == 7)) begin
        errors++;
        $display("[TB] FAIL single_flags col %0d: valid=%b first=%b last=%b, expected 1 %b %b",
                 c, out_valid, out_first, out_last, (c == 0), (c == 7));
      end
      checks++;
      if (q_all !== exp_col(0, c)) begin
        errors++;
        $display("[TB] FAIL single_data col %0d: got %h expected %h", c, q_all, exp_col(0, c));
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_end_flags: valid=%b first=%b last=%b, expected 0 0 0", out_valid, out_first, out_last);
    end
    checks++;
    if (q_all !== exp_col(0, 7)) begin
      errors++;
      $display("[TB] FAIL single_hold: got %h expected %h", q_all, exp_col(0, 7));
    end
  endtask

  task automatic test_back_to_back();
    int firsts;
    int first_t [2];
    bit exp_v;
    int c;
    int mode;
    firsts = 0;
    first_t[0] = 0;
    first_t[1] = 0;
    for (int t = 0; t < 26; t++) begin
      if (t < 8)       set_row(0, t);
      else if (t < 16) set_row(1, t - 8);
      else             set_idle();
      tick();
      exp_v = (t >= 8 && t < 24);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("[TB] FAIL b2b_valid t=%0d: valid=%b expected %b", t, out_valid, exp_v);
      end
      if (exp_v) begin
        c = (t - 8) % 8;
        mode = (t < 16) ? 0 : 1;
        checks++;
        if (out_first !== (c == 0) || out_last !== (c == 7)) begin
          errors++;
          $display("[TB] FAIL b2b_flags t=%0d: first=%b last=%b expected %b %b", t, out_first, out_last, (c == 0), (c == 7));
        end
        checks++;
        if (q_all !== exp_col(mode, c)) begin
          errors++;
          $display("[TB] FAIL b2b_data t=%0d: got %h expected %h", t, q_all, exp_col(mode, c));
        end
      end
      if (out_first === 1'b1) begin
        if (firsts < 2) first_t[firsts] = t;
        firsts++;
      end
    end
    checks++;
    if (firsts != 2 || (first_t[1] - first_t[0]) != 8) begin
      errors++;
      $display("[TB] FAIL b2b_first_count: count=%0d spacing=%0d, expected 2 and 8", firsts, first_t[1] - first_t[0]);
    end
  endtask

  task automatic test_extremes();
    for (int r = 0; r < 8; r++) begin
      set_row(2, r);
      tick();
    end
    set_idle();
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || q0 !== -11'sd1024 || q1 !== 11'sd1023 || q_all !== exp_col(2, c)) begin
        errors++;
        $display("[TB] FAIL extremes col %0d: valid=%b got %h expected %h", c, out_valid, q_all, exp_col(2, c));
      end
    end
    tick();
  endtask

  task automatic test_gapped();
    logic [19:0] gap_pat;
    int r;
    gap_pat = 20'hA9249;
    r = 0;
    for (int t = 0; t < 20; t++) begin
      if (gap_pat[t]) begin
        set_row(0, r);
        r++;
      end else begin
        set_idle();
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL gapped_early t=%0d: valid=%b expected 0", t, out_valid);
      end
    end
    set_idle();
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_first !== (c == 0) || out_last !== (c == 7) || q_all !== exp_col(0, c)) begin
        errors++;
        $display("[TB] FAIL gapped col %0d: valid=%b first=%b last=%b got %h expected %h",
                 c, out_valid, out_first, out_last, q_all, exp_col(0, c));
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_block();
    for (int r = 0; r < 5; r++) begin
      set_row(1, r);
      tick();
    end
    set_idle();
    rst_n = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0 || q_all !== '0) begin
      errors++;
      $display("[TB] FAIL rst_block_clear: valid=%b first=%b last=%b q=%h, expected all 0",
               out_valid, out_first, out_last, q_all);
    end
    rst_n = 1'b1;
    for (int r = 0; r < 8; r++) begin
      set_row(0, r);
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rst_block_early row %0d: valid=%b expected 0", r, out_valid);
      end
    end
    set_idle();
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_first !== (c == 0) || q_all !== exp_col(0, c)) begin
        errors++;
        $display("[TB] FAIL rst_block_data col %0d: valid=%b first=%b got %h expected %h",
                 c, out_valid, out_first, q_all, exp_col(0, c));
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    for (int r = 0; r < 8; r++) begin
      set_row(0, r);
      tick();
    end
    set_idle();
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (out_valid !== 1'b1 || q_all !== exp_col(0, 3)) begin
      errors++;
      $display("[TB] FAIL rst_read_col3: valid=%b got %h expected %h", out_valid, q_all, exp_col(0, 3));
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || q_all !== '0) begin
      errors++;
      $display("[TB] FAIL rst_read_drop: valid=%b q=%h, expected 0 and 0", out_valid, q_all);
    end
    for (int t = 0; t < 8; t++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rst_read_quiet t=%0d: valid=%b expected 0", t, out_valid);
      end
    end
    for (int r = 0; r < 8; r++) begin
      set_row(1, r);
      tick();
    end
    set_idle();
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_last !== (c == 7) || q_all !== exp_col(1, c)) begin
        errors++;
        $display("[TB] FAIL rst_read_next col %0d: valid=%b last=%b got %h expected %h",
                 c, out_valid, out_last, q_all, exp_col(1, c));
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    $display("[TB] starting dct_transpose bench");
    test_reset();
    test_single_block();
    test_back_to_back();
    test_extremes();
    test_gapped();
    test_reset_mid_block();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dct_transpose.md
# dct_transpose

Ping-pong transpose buffer between the row-pass and column-pass 1-D DCT stages of the 8×8 2-D DCT. It consumes the row pass's eight signed coefficients per valid cycle. After a block of eight rows is collected, it emits the block column by column, one 8-coefficient column per cycle, as input to the column pass. Two banks let block N be read out while block N+1 is written, so the block sustains one row per cycle with no backpressure.

## Interface
Parameters:
- W, 11: coefficient width in bits (signed), matches the row-pass output width.
- N, 8: block dimension. Fixed at 8 for this design; other values are unsupported.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  d0..d7 hold one row this cycle; always accepted (no ready).
- d0..d7  input  W each  signed row coefficients, d_c = column c.
- out_valid  output  1  q0..q7 hold one column this cycle.
- q0..q7  output  W each  signed column coefficients, q_r = row r.
- out_first  output  1  high with column 0 of a block.
- out_last  output  1  high with column 7 of a block.

## Operation
- Storage: two banks, each 8×8×W registers. Write bank select `wsel` and read bank = the other bank.
- Write side:
  - Row counter `wrow` (3 bits).
  - On each in_valid, store d0..d7 into bank[wsel] row wrow, then increment wrow.
  - When the row at wrow=7 is stored, wrow wraps to 0, `wsel` toggles, and a read of the just-filled bank is launched.
- Read side:
  - States are IDLE and READ.
  - A launch moves IDLE to READ with column counter `rcol`=0.
  - In READ, each cycle registers q_r = bank[rd][r][rcol] for r=0..7, asserts out_valid, and increments rcol.
  - After rcol=7 the FSM returns to IDLE, unless a new launch arrived on that same edge; in that case it stays in READ with rcol=0 on the other bank.
- Overflow cannot occur. A read takes exactly 8 cycles, and the next block needs at least 8 row-cycles. A launch therefore never finds READ with rcol<7.
- Gaps in in_valid stall only the write side. Once launched, a read runs 8 contiguous cycles regardless of in_valid.
- Data is a pure copy. There is no arithmetic, rounding or saturation, and values pass bit-exact, including -2^(W-1).
- When out_valid=0, q0..q7 hold their last values; out_first and out_last are 0.

## Timing
- Reset:
  - out_valid, out_first, out_last = 0; q0..q7 = 0.
  - wrow=0, wsel=0, FSM=IDLE.
  - Bank contents are don't-care.
  - A reset during a partial block discards that block. A reset mid-read truncates the read; no further out_valid until a new full block arrives.
- Latency:
  - The row 7 sample edge E launches the read.
  - Column 0 is registered on E+1, so out_valid is high in the cycle following E+1.
  - Columns 1..7 follow on the next 7 consecutive cycles.
  - Latency from row 7 presented to column 0 presented is 2 cycles.
- Throughput is one row in and one column out per cycle, sustained indefinitely with back-to-back blocks. out_valid stays continuously high across block boundaries; out_first marks each block.
- Simultaneous events: a row write into bank[wsel] and a column read from the other bank in the same cycle never conflict.

## Structure
- Shared package `dct_pkg`:
  - Constants DCT_N=8 and DCT_COEF_W=11.
  - Read FSM state enum {IDLE, READ}.
- One sub-module `tp_bank`: an 8×8×W register array with a row write port (we, row index, 8 words) and a column read port (col index, 8 words). It is instantiated twice.
- The top module holds wrow, wsel, the read FSM and the output registers.

## Test plan
- Single block: rows d_c = 8r+c, r=0..7, on consecutive cycles.
  - Expect out_valid for exactly 8 cycles, starting 2 cycles after row 7.
  - Column c gives q_r = 8r+c.
  - out_first with c=0 and out_last with c=7.
- Back-to-back blocks: block A as above, then block B with d_c = -(8r+c) immediately after.
  - Expect 16 contiguous out_valid cycles, A's columns then B's.
  - out_first fires exactly twice, 8 cycles apart.
- Extremes: all d = -1024 in even rows and +1023 in odd rows.
  - Every column gives q_even = -1024 and q_odd = 1023, bit-exact.
- Gapped input: in_valid 1,0,0,1,… spreading 8 rows over 20 cycles.
  - Output equals the single-block case and starts 2 cycles after the last row.
  - No out_valid earlier.
- Reset mid-block: 5 rows in, rst_n low for 1 cycle, then a full 8-row block.
  - Only the new block is emitted, with correct data.
  - All outputs are 0 in the cycle after reset.
- Reset mid-read: assert rst_n low during column 3.
  - out_valid drops the next cycle, remaining columns are never emitted, and a following block reads out correctly from bank 0.
